// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle for bcd_updown_counter.
// The counter sits on the slave modport. Whatever drives run/dir/wrap_en/max_count uses master.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 2,
  parameter int MAX_W  = 7
);
  logic                  run;
  logic                  dir;
  logic                  wrap_en;
  logic [MAX_W-1:0]      max_count;
  logic [4*DIGITS-1:0]   digits;
  logic                  busy;
  logic                  done;
  logic                  tc_pulse;

  modport master (
    output run, dir, wrap_en, max_count,
    input  digits, busy, done, tc_pulse
  );

  modport slave (
    input  run, dir, wrap_en, max_count,
    output digits, busy, done, tc_pulse
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with a clamped binary limit, a prescaler and an optional wrap mode.
// A rising edge on run loads the counter. Holding run low keeps it cleared.
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter int MAX_W  = 7,
  parameter int DIV    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  bcd_updown_counter_if.slave  bus
);
  localparam int          W         = 4 * DIGITS;
  localparam int          PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [31:0] LIMIT_MAX = 32'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    limit_q, limit_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            dir_q, dir_d;
  logic            wrap_q, wrap_d;
  logic            run_q;
  logic            busy_q, done_q, tc_q, tc_d;

  // Double-dabble conversion. The input is already clamped, so every partial result fits in W bits.
  function automatic logic [W-1:0] bin2bcd(input logic [31:0] bin);
    logic [W-1:0] bcd;
    bcd = '0;
    for (int i = 31; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++)
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      bcd = {bcd[W-2:0], bin[i]};
    end
    return bcd;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++)
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
        else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int d = 0; d < DIGITS; d++)
      if (borrow) begin
        if (v[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'd9;
        else begin
          r[4*d +: 4] = v[4*d +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    return r;
  endfunction

  logic          start, tick;
  logic [31:0]   max_ext, clamp_bin;
  logic [W-1:0]  new_limit, new_start, new_term;
  logic [W-1:0]  start_val, term_val, stepped;

  assign start     = bus.run & ~run_q;
  assign tick      = (presc_q == PW'(DIV - 1));
  assign max_ext   = 32'(bus.max_count);
  assign clamp_bin = (max_ext > LIMIT_MAX) ? LIMIT_MAX : max_ext;
  assign new_limit = bin2bcd(clamp_bin);
  assign new_start = bus.dir ? new_limit : '0;
  assign new_term  = bus.dir ? '0 : new_limit;
  assign start_val = dir_q ? limit_q : '0;
  assign term_val  = dir_q ? '0 : limit_q;
  assign stepped   = dir_q ? bcd_dec(count_q) : bcd_inc(count_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    wrap_d  = wrap_q;
    tc_d    = 1'b0;

    if (!bus.run) begin
      state_d = IDLE;
      count_d = '0;
      presc_d = '0;
    end else if (start) begin
      limit_d = new_limit;
      dir_d   = bus.dir;
      wrap_d  = bus.wrap_en;
      count_d = new_start;
      presc_d = '0;
      state_d = (new_start == new_term && !bus.wrap_en) ? DONE : COUNT;
    end else if (state_q == COUNT) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (count_q == term_val) begin
          if (wrap_q) begin
            count_d = start_val;
            tc_d    = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          count_d = stepped;
          if (stepped == term_val && !wrap_q) state_d = DONE;
        end
      end
    end
  end

  // Status flags come from the next state, so they line up with the state register on every cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      presc_q <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample pre-edge values, which avoids ordering races.
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      run_q   <= bus.run;
      busy_q  <= (state_d == COUNT);
      done_q  <= (state_d == DONE);
      tc_q    <= tc_d;
    end
  end

  assign bus.digits   = count_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tc_pulse = tc_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: up, down, clamp, wrap, zero limit, restart, reset and the prescaler.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_bcd_updown_counter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_updown_counter_if #(.DIGITS(2), .MAX_W(7)) bus1 ();
  bcd_updown_counter_if #(.DIGITS(2), .MAX_W(7)) bus4 ();

  bcd_updown_counter #(.DIGITS(2), .MAX_W(7), .DIV(1)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));
  bcd_updown_counter #(.DIGITS(2), .MAX_W(7), .DIV(4)) dut4 (.CLK(clk), .RST(rst), .bus(bus4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected two-digit BCD encoding of 0..99.
  function automatic logic [31:0] bcd2(input int k);
    return 32'(((k / 10) << 4) | (k % 10));
  endfunction

  // Drives a start on bus1. run must have been low at the previous edge. Returns just after the load edge.
  task automatic arm1(input logic [6:0] max, input logic d, input logic w);
    bus1.max_count = max;
    bus1.dir       = d;
    bus1.wrap_en   = w;
    bus1.run       = 1'b1;
    step();
  endtask

  task automatic idle1();
    bus1.run = 1'b0;
    step();
    check("idle_digits", 32'(bus1.digits), 32'h0);
    check("idle_busy",   32'(bus1.busy),   32'd0);
    check("idle_done",   32'(bus1.done),   32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus1.run = 1'b0; bus1.dir = 1'b0; bus1.wrap_en = 1'b0; bus1.max_count = '0;
    bus4.run = 1'b0; bus4.dir = 1'b0; bus4.wrap_en = 1'b0; bus4.max_count = '0;
    repeat (2) step();
    check("rst_digits", 32'(bus1.digits),   32'h0);
    check("rst_busy",   32'(bus1.busy),     32'd0);
    check("rst_done",   32'(bus1.done),     32'd0);
    check("rst_tc",     32'(bus1.tc_pulse), 32'd0);
    rst = 1'b0;
    step();
    check("idle_after_rst", 32'(bus4.busy), 32'd0);

    // Count up to 73. Input changes made mid-count must be ignored.
    arm1(7'd73, 1'b0, 1'b0);
    check("t1_load", 32'(bus1.digits), 32'h0);
    check("t1_busy", 32'(bus1.busy),   32'd1);
    for (int k = 1; k <= 73; k++) begin
      if (k == 40) begin
        bus1.max_count = 7'd15;
        bus1.dir       = 1'b1;
        bus1.wrap_en   = 1'b1;
      end
      step();
      check("t1_digits", 32'(bus1.digits), bcd2(k));
      check("t1_done",   32'(bus1.done),   32'(k == 73));
    end
    check("t1_busy_end", 32'(bus1.busy), 32'd0);
    repeat (3) step();
    check("t1_hold", 32'(bus1.digits), 32'h73);
    check("t1_hold_done", 32'(bus1.done), 32'd1);
    idle1();

    // A limit of 118 must clamp to 99.
    arm1(7'd118, 1'b0, 1'b0);
    repeat (98) step();
    check("t2_98", 32'(bus1.digits), 32'h98);
    check("t2_98_done", 32'(bus1.done), 32'd0);
    step();
    check("t2_99", 32'(bus1.digits), 32'h99);
    check("t2_done", 32'(bus1.done), 32'd1);
    step();
    check("t2_no_wrap", 32'(bus1.digits), 32'h99);
    idle1();

    // Count down from 15. This exercises the borrow from 10 to 09.
    arm1(7'd15, 1'b1, 1'b0);
    check("t3_load", 32'(bus1.digits), 32'h15);
    for (int k = 1; k <= 15; k++) begin
      step();
      check("t3_digits", 32'(bus1.digits), bcd2(15 - k));
    end
    check("t3_done", 32'(bus1.done), 32'd1);
    check("t3_busy", 32'(bus1.busy), 32'd0);
    // While run stays high in DONE, the count must not restart.
    repeat (3) step();
    check("t3_hold_done", 32'(bus1.done), 32'd1);
    check("t3_hold_busy", 32'(bus1.busy), 32'd0);
    // Drop run for one cycle, then raise it: expect one IDLE cycle, then a reload.
    idle1();
    arm1(7'd15, 1'b1, 1'b0);
    check("t3_reload", 32'(bus1.digits), 32'h15);
    check("t3_reload_busy", 32'(bus1.busy), 32'd1);
    idle1();

    // Wrap with limit 9.
    arm1(7'd9, 1'b0, 1'b1);
    check("t4_load", 32'(bus1.digits), 32'h0);
    for (int k = 1; k <= 25; k++) begin
      step();
      check("t4_digits", 32'(bus1.digits),   bcd2(k % 10));
      check("t4_tc",     32'(bus1.tc_pulse), 32'((k % 10) == 0));
      check("t4_done",   32'(bus1.done),     32'd0);
    end
    idle1();
    check("t4_tc_idle", 32'(bus1.tc_pulse), 32'd0);

    // Limit 0 without wrap: DONE on the load edge.
    arm1(7'd0, 1'b0, 1'b0);
    check("z_done", 32'(bus1.done), 32'd1);
    check("z_busy", 32'(bus1.busy), 32'd0);
    idle1();
    // Limit 0 with wrap: tc_pulse on every tick, digits stay 0.
    arm1(7'd0, 1'b1, 1'b1);
    check("zw_busy", 32'(bus1.busy), 32'd1);
    check("zw_tc0",  32'(bus1.tc_pulse), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("zw_tc", 32'(bus1.tc_pulse), 32'd1);
      check("zw_digits", 32'(bus1.digits), 32'h0);
    end
    idle1();

    // A reset pulse at 42 with run held high. The first non-reset edge starts a new count.
    arm1(7'd99, 1'b0, 1'b0);
    repeat (42) step();
    check("r_42", 32'(bus1.digits), 32'h42);
    rst = 1'b1;
    step();
    check("r_digits", 32'(bus1.digits), 32'h0);
    check("r_busy",   32'(bus1.busy),   32'd0);
    rst = 1'b0;
    step();
    check("r_restart", 32'(bus1.digits), 32'h0);
    check("r_restart_busy", 32'(bus1.busy), 32'd1);
    step();
    check("r_step", 32'(bus1.digits), 32'h01);
    idle1();

    // Prescaler of 4 with limit 3: a step every 4 clocks, DONE 12 clocks after the load.
    bus4.max_count = 7'd3;
    bus4.dir       = 1'b0;
    bus4.wrap_en   = 1'b0;
    bus4.run       = 1'b1;
    step();
    check("p_load", 32'(bus4.digits), 32'h0);
    for (int n = 1; n <= 12; n++) begin
      step();
      check("p_digits", 32'(bus4.digits), 32'(n / 4));
      check("p_done",   32'(bus4.done),   32'(n == 12));
    end
    bus4.run = 1'b0;
    step();
    check("p_idle", 32'(bus4.digits), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
